// File: rtl/countdown_display_driver.sv
// countdown_display_driver: latches a 0..31 count, scans it as two decimal digits on a
// 4-digit common-anode seven-segment display, blinks at zero and pulses done on reaching zero.
module countdown_display_driver #(
  parameter logic [27:0] REFRESH_DIV = 28'd100000,
  parameter logic [27:0] BLINK_DIV   = 28'd25000000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic [4:0] countdown,
  input  logic       count_valid,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       done
);
  logic [4:0]  value_q, value_d, ones;
  logic        armed_q, armed_d, done_q, done_d, blink_q, blink_d;
  logic [27:0] scan_q, scan_d, blink_cnt_q, blink_cnt_d;
  logic [1:0]  slot_q, slot_d, tens;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        scan_wrap, blink_wrap, zero;

  function automatic logic [6:0] seg7(input logic [4:0] d);
    case (d)
      5'd0: seg7 = 7'b1000000;
      5'd1: seg7 = 7'b1111001;
      5'd2: seg7 = 7'b0100100;
      5'd3: seg7 = 7'b0110000;
      5'd4: seg7 = 7'b0011001;
      5'd5: seg7 = 7'b0010010;
      5'd6: seg7 = 7'b0000010;
      5'd7: seg7 = 7'b1111000;
      5'd8: seg7 = 7'b0000000;
      5'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    value_d     = count_valid ? countdown : value_q;
    armed_d     = armed_q | (count_valid & (countdown != 5'd0));
    done_d      = count_valid & (countdown == 5'd0) & (value_q != 5'd0);
    scan_wrap   = scan_q == REFRESH_DIV - 28'd1;
    scan_d      = scan_wrap ? 28'd0 : scan_q + 28'd1;
    slot_d      = slot_q + {1'b0, scan_wrap};
    zero        = armed_q & (value_q == 5'd0);
    blink_wrap  = blink_cnt_q == BLINK_DIV - 28'd1;
    blink_cnt_d = (!zero || blink_wrap) ? 28'd0 : blink_cnt_q + 28'd1;
    blink_d     = zero & (blink_q ^ blink_wrap);
    tens        = value_q >= 5'd30 ? 2'd3 : value_q >= 5'd20 ? 2'd2 : value_q >= 5'd10 ? 2'd1 : 2'd0;
    ones        = value_q - 5'(tens) * 5'd10;
    // blink gating uses the live zero state so leaving zero relights on the very next update
    an_d        = (zero & blink_q) ? 4'b1111 :
                  slot_q == 2'd0 ? 4'b1110 :
                  (slot_q == 2'd1 && tens != 2'd0) ? 4'b1101 : 4'b1111;
    seg_d       = an_d == 4'b1111 ? 7'b1111111 : seg7(slot_q == 2'd0 ? ones : {3'b000, tens});
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      value_q     <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      scan_q      <= '0;
      slot_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
    end else begin
      value_q     <= value_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      scan_q      <= scan_d;
      slot_q      <= slot_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign done = done_q;
endmodule

// File: tb/tb_countdown_display_driver.sv
// tb_countdown_display_driver: directed checks of scan timing, digit encoding, blink and done
// with REFRESH_DIV=4, BLINK_DIV=8; k counts clock edges since the last reset release.
module tb_countdown_display_driver;
  logic       clk = 1'b0;
  logic       reset, count_valid;
  logic [4:0] countdown;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, done;
  int checks = 0, errors = 0, k = 0;

  countdown_display_driver #(.REFRESH_DIV(28'd4), .BLINK_DIV(28'd8)) dut (
    .clock_in(clk), .reset(reset), .countdown(countdown), .count_valid(count_valid),
    .an(an), .seg(seg), .dp(dp), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0b expected %0b", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  task automatic disp(input string tag, input logic [3:0] ea, input logic [6:0] es);
    chk({tag, "_an"}, {28'd0, an}, {28'd0, ea});
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, es});
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    k = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at k=%0d", k);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; count_valid = 1'b0; countdown = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    disp("rst_held", 4'b1111, 7'b1111111);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    #2 reset = 1'b0;
    k = 0;
    tick();
    disp("first_slot0", 4'b1110, 7'b1000000);
    chk("first_done", {31'd0, done}, 32'd0);
    // 27 captured at edge 2
    countdown = 5'd27; count_valid = 1'b1;
    tick();
    count_valid = 1'b0;
    run_to(17); disp("s27_slot0_a", 4'b1110, 7'b1111000);
    run_to(20); disp("s27_slot0_b", 4'b1110, 7'b1111000);
    run_to(21); disp("s27_slot1_a", 4'b1101, 7'b0100100);
    run_to(24); disp("s27_slot1_b", 4'b1101, 7'b0100100);
    run_to(25); disp("s27_slot2", 4'b1111, 7'b1111111);
    run_to(29); disp("s27_slot3", 4'b1111, 7'b1111111);
    // 5 captured at edge 30
    countdown = 5'd5; count_valid = 1'b1;
    tick();
    count_valid = 1'b0;
    run_to(33); disp("s5_slot0", 4'b1110, 7'b0010010);
    run_to(37); disp("s5_slot1_blank", 4'b1111, 7'b1111111);
    // 1 at edge 42, 0 at edge 43: blink lit 44..51, dark 52..59, lit 60..67, dark 68..75
    run_to(41);
    countdown = 5'd1; count_valid = 1'b1;
    tick();
    chk("done_before", {31'd0, done}, 32'd0);
    countdown = 5'd0;
    tick();
    count_valid = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    tick();
    chk("done_after", {31'd0, done}, 32'd0);
    run_to(49); disp("blink_lit_a", 4'b1110, 7'b1000000);
    run_to(51); disp("blink_lit_b", 4'b1110, 7'b1000000);
    run_to(52); disp("blink_dark_a", 4'b1111, 7'b1111111);
    run_to(65); disp("blink_lit_c", 4'b1110, 7'b1000000);
    run_to(68); disp("blink_dark_b", 4'b1111, 7'b1111111);
    countdown = 5'd0; count_valid = 1'b1;
    tick();
    count_valid = 1'b0;
    chk("zero_again_a", {31'd0, done}, 32'd0);
    tick();
    chk("zero_again_b", {31'd0, done}, 32'd0);
    // async reset mid-slot1 while blinking, sampled before the next edge
    #1 reset = 1'b1;
    #1;
    disp("async_rst", 4'b1111, 7'b1111111);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    release_reset();
    // capture 0 straight after reset: no pulse, no blink
    countdown = 5'd0; count_valid = 1'b1;
    tick();
    count_valid = 1'b0;
    disp("r2_slot0", 4'b1110, 7'b1000000);
    chk("unarmed_done_a", {31'd0, done}, 32'd0);
    tick();
    chk("unarmed_done_b", {31'd0, done}, 32'd0);
    run_to(17); disp("unarmed_lit_a", 4'b1110, 7'b1000000);
    run_to(36); disp("unarmed_lit_b", 4'b1110, 7'b1000000);
    // 1 at edge 37, 0 at edge 38: dark 47..54
    countdown = 5'd1; count_valid = 1'b1;
    tick();
    countdown = 5'd0;
    tick();
    count_valid = 1'b0;
    chk("done_pulse2", {31'd0, done}, 32'd1);
    tick();
    chk("done_after2", {31'd0, done}, 32'd0);
    run_to(49); disp("dark_slot0", 4'b1111, 7'b1111111);
    countdown = 5'd31; count_valid = 1'b1;
    tick();
    count_valid = 1'b0;
    disp("dark_before_31", 4'b1111, 7'b1111111);
    tick(); disp("s31_slot0", 4'b1110, 7'b1111001);
    run_to(53); disp("s31_slot1", 4'b1101, 7'b0110000);
    run_to(65); disp("s31_slot0_later", 4'b1110, 7'b1111001);
    chk("s31_done", {31'd0, done}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
